ctrl_cmd_arbiter: RTL and testbench

- Shares the single controller command FIFO write port among NUM_REQ command sources: initial_dram, io_schedule, table write-back and GC.
- Each requester presents one command plus an 8-bit channel enable under a valid/ready handshake.
- The arbiter selects one requester round-robin, gated by all_Cmd_Available_flag, and drives controller_command_fifo_in and controller_command_fifo_in_en.
- A programmable idle gap follows every write so the availability flag can settle.

---
 rtl/ctrl_cmd_arbiter.sv | 121 ++++++++++++
 tb/tb_ctrl_cmd_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_cmd_arbiter.sv
// Arbitrates NUM_REQ command sources onto the single controller command FIFO write port,
// with a programmable idle gap after each write. Define CTRL_CMD_ARB_FIXED_PRIORITY_EN for fixed priority.
module ctrl_cmd_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int COMMAND_WIDTH = 128,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               all_Cmd_Available_flag,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*COMMAND_WIDTH-1:0]   req_cmd,
  input  logic [NUM_REQ*8-1:0]               req_chan_en,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [COMMAND_WIDTH-1:0]           controller_command_fifo_in,
  output logic [7:0]                         controller_command_fifo_in_en,
  output logic                               zero_en_drop,
  output logic [31:0]                        cmd_issue_count
);

  localparam int         IDX_W    = $clog2(NUM_REQ);
  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

  typedef enum logic {S_IDLE, S_GAP} state_e;

  state_e                   state_q;
  logic [IDX_W-1:0]         last_grant_q;
  logic [3:0]               gap_q;
  logic [COMMAND_WIDTH-1:0] fifo_in_q;
  logic [7:0]               fifo_en_q;
  logic                     zero_drop_q;
  logic [31:0]              count_q;

  logic                     grant_found;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant;
  logic [COMMAND_WIDTH-1:0] sel_cmd;
  logic [7:0]               sel_en;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    int r;
    r = v % NUM_REQ;
    return r[IDX_W-1:0];
  endfunction

  // Winner search; iterating from the far end lets the nearest candidate overwrite the result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = '0;
`ifdef CTRL_CMD_ARB_FIXED_PRIORITY_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
`else
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[wrap_idx(int'(last_grant_q) + k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(int'(last_grant_q) + k);
      end
    end
`endif
  end

  // The flag is only honoured in IDLE; reset also blocks the combinational accept strobe.
  assign grant   = reset && (state_q == S_IDLE) && all_Cmd_Available_flag && grant_found;
  assign sel_cmd = req_cmd[int'(grant_idx)*COMMAND_WIDTH +: COMMAND_WIDTH];
  assign sel_en  = req_chan_en[int'(grant_idx)*8 +: 8];

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the data register is reset too, so the FIFO bus reads zero after reset rather than stale data.
      fifo_in_q    <= '0;
      fifo_en_q    <= '0;
      zero_drop_q  <= 1'b0;
      count_q      <= '0;
      gap_q        <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      state_q      <= S_IDLE;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            fifo_in_q    <= sel_cmd;
            fifo_en_q    <= sel_en;
            zero_drop_q  <= (sel_en == 8'h00);
            if (sel_en != 8'h00) count_q <= count_q + 32'd1;
            last_grant_q <= grant_idx;
            gap_q        <= GAP_INIT;
            state_q      <= S_GAP;
          end else begin
            fifo_en_q   <= '0;
            zero_drop_q <= 1'b0;
          end
        end
        S_GAP: begin
          fifo_en_q   <= '0;
          zero_drop_q <= 1'b0;
          gap_q       <= gap_q - 4'd1;
          if (gap_q <= 4'd1) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign controller_command_fifo_in    = fifo_in_q;
  assign controller_command_fifo_in_en = fifo_en_q;
  assign zero_en_drop                  = zero_drop_q;
  assign cmd_issue_count               = count_q;

endmodule

// File: tb/tb_ctrl_cmd_arbiter.sv
// Scoreboard bench for ctrl_cmd_arbiter: stimulus pushes expected FIFO writes, a negedge monitor pops them.
module tb_ctrl_cmd_arbiter;

  localparam int NR = 4;
  localparam int CW = 128;

  logic            clk = 1'b0;
  logic            reset;
  logic            flag;
  logic [NR-1:0]   req_valid;
  logic [NR*CW-1:0] req_cmd;
  logic [NR*8-1:0] req_chan_en;
  logic [CW-1:0]   cmd_tab [NR];
  logic [7:0]      chan_tab[NR];

  logic [NR-1:0]   req_ready;
  logic [CW-1:0]   fifo_in;
  logic [7:0]      fifo_en;
  logic            zero_drop;
  logic [31:0]     count;

  logic [NR-1:0]   r3_ready;
  logic [CW-1:0]   r3_fifo_in;
  logic [7:0]      r3_en;
  logic            r3_zero;
  logic [31:0]     r3_count;

  assign req_cmd     = {cmd_tab[3], cmd_tab[2], cmd_tab[1], cmd_tab[0]};
  assign req_chan_en = {chan_tab[3], chan_tab[2], chan_tab[1], chan_tab[0]};

  always #5 clk = ~clk;

  ctrl_cmd_arbiter #(.NUM_REQ(NR), .COMMAND_WIDTH(CW), .GAP_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .all_Cmd_Available_flag(flag),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_chan_en(req_chan_en),
    .req_ready(req_ready), .controller_command_fifo_in(fifo_in),
    .controller_command_fifo_in_en(fifo_en), .zero_en_drop(zero_drop),
    .cmd_issue_count(count));

  ctrl_cmd_arbiter #(.NUM_REQ(NR), .COMMAND_WIDTH(CW), .GAP_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .all_Cmd_Available_flag(flag),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_chan_en(req_chan_en),
    .req_ready(r3_ready), .controller_command_fifo_in(r3_fifo_in),
    .controller_command_fifo_in_en(r3_en), .zero_en_drop(r3_zero),
    .cmd_issue_count(r3_count));

  typedef struct {
    int          req;
    logic [CW-1:0] cmd;
    logic [7:0]  en;
    logic        zero;
    logic [31:0] cnt;
    int          gap;
  } exp_t;

  exp_t    sb[$];
  int      n_vec = 0;
  int      n_err = 0;
  int      cyc = 0;
  bit      mon_en = 1'b0;
  logic [NR-1:0] one_shot;
  logic [NR-1:0] rdy_s;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int req, input logic [31:0] cnt, input int gap);
    exp_t e;
    e.req  = req;
    e.cmd  = cmd_tab[req];
    e.en   = chan_tab[req];
    e.zero = (chan_tab[req] == 8'h00);
    e.cnt  = cnt;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  // Advance one cycle; one-shot requesters withdraw after their accept strobe.
  task automatic tick();
    @(negedge clk);
    rdy_s = req_ready;
    @(posedge clk);
    #2;
    req_valid = req_valid & ~(rdy_s & one_shot);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a write (or a zero-enable drop) is matched to the grant strobe seen one cycle earlier.
  logic [NR-1:0] prev_ready = '0;
  int            last_evt = 0;
  always @(negedge clk) begin
    if (reset && mon_en) begin
      if (req_ready != '0) check("ready_onehot", CW'($onehot(req_ready)), CW'(1));
      if (fifo_en != 8'h00 || zero_drop) begin
        if (sb.size() == 0) begin
          check("unexpected_write_en", CW'(fifo_en), CW'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("grant_ready", CW'(prev_ready), CW'(1) << e.req);
          check("fifo_in", fifo_in, e.cmd);
          check("fifo_in_en", CW'(fifo_en), CW'(e.en));
          check("zero_en_drop", CW'(zero_drop), CW'(e.zero));
          check("issue_count", CW'(count), CW'(e.cnt));
          if (e.gap > 0) check("write_spacing", CW'(cyc - last_evt), CW'(e.gap));
        end
        last_evt = cyc;
      end
    end
    prev_ready = req_ready;
  end

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    cmd_tab[0] = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    cmd_tab[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    cmd_tab[2] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98;
    cmd_tab[3] = 128'hC3C3_C3C3_C3C3_C3C3_C3C3_C3C3_C3C3_C3C3;
    chan_tab[0] = 8'h04; chan_tab[1] = 8'h02; chan_tab[2] = 8'h20; chan_tab[3] = 8'h80;
    reset = 1'b0; flag = 1'b1; req_valid = 4'b0001; one_shot = 4'b1111;

    // Reset state with a request already pending.
    tick(); tick();
    check("rst_ready", CW'(req_ready), CW'(0));
    check("rst_fifo_in", fifo_in, CW'(0));
    check("rst_fifo_en", CW'(fifo_en), CW'(0));
    check("rst_zero", CW'(zero_drop), CW'(0));
    check("rst_count", CW'(count), CW'(0));
    check("rst3_count", CW'(r3_count), CW'(0));

    // Single request on release: accepted at the first edge, enable for one cycle.
    mon_en = 1'b1;
    push_exp(0, 32'd1, 0);
    reset = 1'b1;
    tick(); tick();
    check("t1_en_dropped", CW'(fifo_en), CW'(0));
    check("t1_count_hold", CW'(count), CW'(1));

    // All requesters continuously valid.
    req_valid = 4'b1111; one_shot = 4'b0000;
`ifdef CTRL_CMD_ARB_FIXED_PRIORITY_EN
    push_exp(0, 32'd1, 0); push_exp(0, 32'd2, 2); push_exp(0, 32'd3, 2);
    push_exp(0, 32'd4, 2); push_exp(0, 32'd5, 2);
`else
    push_exp(0, 32'd1, 0); push_exp(1, 32'd2, 2); push_exp(2, 32'd3, 2);
    push_exp(3, 32'd4, 2); push_exp(0, 32'd5, 2);
`endif
    apply_reset();
    for (int i = 0; i < 10; i++) tick();
    check("t2_count_10cyc", CW'(count), CW'(5));
    req_valid = 4'b0000; one_shot = 4'b1111;
    tick(); tick();

    // Flag held low blocks grants; requester 1 then 2 once it rises.
    chan_tab[1] = 8'h01; chan_tab[2] = 8'h02;
    flag = 1'b0; req_valid = 4'b0110;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t3_flag_low_ready", CW'(rdy_s), CW'(0));
      check("t3_flag_low_en", CW'(fifo_en), CW'(0));
    end
    push_exp(1, 32'd1, 0); push_exp(2, 32'd2, 2);
    flag = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Zero channel enable: accepted, dropped, count unchanged.
    chan_tab[2] = 8'h00;
    push_exp(2, 32'd2, 0);
    req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) tick();
    check("t4_count_unchanged", CW'(count), CW'(2));
    check("t4_zero_cleared", CW'(zero_drop), CW'(0));
    check("sb_drained", CW'(sb.size()), CW'(0));
    mon_en = 1'b0;

    // GAP_CYCLES=3 instance: reset mid-gap clears everything at once.
    req_valid = 4'b0000;
    apply_reset();
    req_valid = 4'b0001;
    #1 check("t5_first_ready", CW'(r3_ready), CW'(1));
    @(posedge clk); #2;
    check("t5_first_en", CW'(r3_en), CW'(8'h04));
    check("t5_first_count", CW'(r3_count), CW'(1));
    @(posedge clk); #2;
    check("t5_in_gap_ready", CW'(r3_ready), CW'(0));
    reset = 1'b0;
    #1;
    check("t5_rst_fifo_in", r3_fifo_in, CW'(0));
    check("t5_rst_en", CW'(r3_en), CW'(0));
    check("t5_rst_count", CW'(r3_count), CW'(0));
    check("t5_rst_ready", CW'(r3_ready), CW'(0));
    @(posedge clk); #2;
    reset = 1'b1;
    #1 check("t5_regrant_ready", CW'(r3_ready), CW'(1));
    check("t5_regrant_count0", CW'(r3_count), CW'(0));
    @(posedge clk); #2;
    check("t5_regrant_count1", CW'(r3_count), CW'(1));
    for (int i = 0; i < 3; i++) begin
      check("t5_gap_no_ready", CW'(r3_ready), CW'(0));
      @(posedge clk); #2;
    end
    check("t5_gap_end_ready", CW'(r3_ready), CW'(1));
    req_valid = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
